// File: rtl/vec_addsub_fixed.sv
// rtl/vec_addsub_fixed.sv - pipelined multi-lane saturating fixed-point add/sub
module vec_addsub_fixed #(
   parameter int LANES     = 4,
   parameter int WIDTH     = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_op,
   input  logic                   in_sat_en,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_result,
   output logic [LANES-1:0]       out_c,
   output logic [LANES-1:0]       out_n,
   output logic [LANES-1:0]       out_v,
   output logic [LANES-1:0]       out_z,
   output logic [LANES-1:0]       sticky_v,
   input  logic                   sticky_clr
);

   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

   logic                   s1_valid;
   logic                   s1_sat;
   logic                   s1_abs;
   logic [WIDTH:0]         s1_r [LANES];
   logic [LANES-1:0]       s1_c;
   logic                   s1_load;
   logic                   s2_load;

   logic [WIDTH:0]         r_next [LANES];
   logic [LANES-1:0]       c_next;
   logic [LANES-1:0]       v_next;
   logic [LANES-1:0]       n_next;
   logic [LANES-1:0]       z_next;
   logic [LANES*WIDTH-1:0] res_next;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   genvar i;
   generate
      for (i = 0; i < LANES; i++) begin : g_lane
         logic [WIDTH:0]       a_x;
         logic [WIDTH:0]       b_x;
         logic [WIDTH:0]       diff;
         logic [FRAC_BITS-1:0] fa;
         logic [FRAC_BITS-1:0] fb;
         logic [FRAC_BITS:0]   fsum;
         logic [WIDTH:0]       r;
         logic                 c;
         logic [WIDTH-1:0]     res;
         logic                 ovf;

         assign a_x  = {in_a[i*WIDTH+WIDTH-1], in_a[i*WIDTH +: WIDTH]};
         assign b_x  = {in_b[i*WIDTH+WIDTH-1], in_b[i*WIDTH +: WIDTH]};
         assign fa   = in_a[i*WIDTH +: FRAC_BITS];
         assign fb   = in_b[i*WIDTH +: FRAC_BITS];
         assign diff = a_x - b_x;
         assign fsum = {1'b0, fa} + {1'b0, fb};

         // Exact WIDTH+1-bit result; for |A-B| the borrow is that of larger minus smaller
         always_comb begin
            r = a_x + b_x;
            c = fsum[FRAC_BITS];
            case (in_op)
               2'b01: begin
                  r = diff;
                  c = fa < fb;
               end
               2'b10: begin
                  r = b_x - a_x;
                  c = fb < fa;
               end
               2'b11: begin
                  r = diff[WIDTH] ? -diff : diff;
                  c = diff[WIDTH] ? (fb < fa) : (fa < fb);
               end
               default: ;
            endcase
         end

         assign r_next[i] = r;
         assign c_next[i] = c;

         // Magnitudes are unsigned, so any bit above the sign position means overflow
         always_comb begin
            if (s1_abs)
               ovf = s1_r[i][WIDTH] | s1_r[i][WIDTH-1];
            else
               ovf = s1_r[i][WIDTH] ^ s1_r[i][WIDTH-1];
            res = s1_r[i][WIDTH-1:0];
            if (s1_sat && ovf)
               res = (s1_r[i][WIDTH] && !s1_abs) ? MINN : MAXP;
         end

         assign res_next[i*WIDTH +: WIDTH] = res;
         assign v_next[i] = ovf;
         assign n_next[i] = res[WIDTH-1];
         assign z_next[i] = (res == '0);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sat   <= 1'b0;
         s1_abs   <= 1'b0;
         s1_c     <= '0;
         for (int k = 0; k < LANES; k++)
            s1_r[k] <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sat <= in_sat_en;
            s1_abs <= (in_op == 2'b11);
            s1_c   <= c_next;
            for (int k = 0; k < LANES; k++)
               s1_r[k] <= r_next[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_c      <= '0;
         out_n      <= '0;
         out_v      <= '0;
         out_z      <= '0;
         sticky_v   <= '0;
      end else begin
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_result <= res_next;
               out_c      <= s1_c;
               out_n      <= n_next;
               out_v      <= v_next;
               out_z      <= z_next;
            end
         end
         // A set in the same cycle as a clear takes priority
         sticky_v <= (sticky_v & ~{LANES{sticky_clr}}) |
                     ((out_valid && out_ready) ? out_v : '0);
      end
   end

endmodule

// File: tb/tb_vec_addsub_fixed.sv
// tb/tb_vec_addsub_fixed.sv - directed bench for vec_addsub_fixed
module tb_vec_addsub_fixed;

   localparam int LANES = 4;
   localparam int WIDTH = 16;
   localparam int FRAC_BITS = 8;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic        in_sat_en;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [3:0]  out_c;
   logic [3:0]  out_n;
   logic [3:0]  out_v;
   logic [3:0]  out_z;
   logic [3:0]  sticky_v;
   logic        sticky_clr;

   vec_addsub_fixed #(.LANES(LANES), .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sat_en(in_sat_en),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_c(out_c), .out_n(out_n), .out_v(out_v), .out_z(out_z),
      .sticky_v(sticky_v), .sticky_clr(sticky_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  op;
      logic        sat;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        n;
      logic        v;
      logic        z;
   } case_t;

   typedef struct packed {
      logic [63:0] res;
      logic [3:0]  c;
      logic [3:0]  n;
      logic [3:0]  v;
      logic [3:0]  z;
   } exp_t;

   // lane-0 vectors with hand-computed results: op sat a b result c n v z
   case_t cases [12] = '{
      '{2'd0, 1'b1, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{2'd0, 1'b1, 16'h7F00, 16'h0200, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0},
      '{2'd0, 1'b0, 16'h7F00, 16'h0200, 16'h8100, 1'b0, 1'b1, 1'b1, 1'b0},
      '{2'd1, 1'b1, 16'h0100, 16'h0180, 16'hFF80, 1'b1, 1'b1, 1'b0, 1'b0},
      '{2'd2, 1'b1, 16'h0100, 16'h0180, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0},
      '{2'd3, 1'b1, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0},
      '{2'd3, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1},
      '{2'd3, 1'b0, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0},
      '{2'd1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0},
      '{2'd0, 1'b1, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0},
      '{2'd0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0},
      '{2'd2, 1'b0, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0}
   };

   int   n_checks = 0;
   int   n_fail = 0;
   int   n_expect = 0;
   int   n_recv = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural reference for the randomised lanes, in plain integer arithmetic
   task automatic model_lane(input logic [1:0] op, input logic sat, input logic [15:0] a,
                             input logic [15:0] b, output logic [15:0] res,
                             output logic c, output logic v);
      int ai, bi, r, fa, fb;
      ai = int'($signed(a));
      bi = int'($signed(b));
      fa = int'(a[7:0]);
      fb = int'(b[7:0]);
      case (op)
         2'd0: begin r = ai + bi; c = (fa + fb) >= 256; end
         2'd1: begin r = ai - bi; c = fa < fb; end
         2'd2: begin r = bi - ai; c = fb < fa; end
         default: begin
            r = (ai >= bi) ? ai - bi : bi - ai;
            c = (ai >= bi) ? (fa < fb) : (fb < fa);
         end
      endcase
      v = (r > 32767) || (r < -32768);
      if (sat && v)
         res = (r > 32767) ? 16'h7FFF : 16'h8000;
      else
         res = r[15:0];
   endtask

   task automatic drive_vec(input int idx, output exp_t e);
      case_t       t;
      logic [63:0] a, b;
      logic [15:0] r;
      logic        c, v;
      t = cases[idx];
      a = '0;
      b = '0;
      a[15:0] = t.a;
      b[15:0] = t.b;
      e.res[15:0] = t.r;
      e.c[0] = t.c;
      e.n[0] = t.n;
      e.v[0] = t.v;
      e.z[0] = t.z;
      for (int i = 1; i < LANES; i++) begin
         a[i*16 +: 16] = 16'($urandom);
         b[i*16 +: 16] = 16'($urandom);
         model_lane(t.op, t.sat, a[i*16 +: 16], b[i*16 +: 16], r, c, v);
         e.res[i*16 +: 16] = r;
         e.c[i] = c;
         e.v[i] = v;
         e.n[i] = r[15];
         e.z[i] = (r == 16'h0);
      end
      in_a      = a;
      in_b      = b;
      in_op     = t.op;
      in_sat_en = t.sat;
      in_valid  = 1'b1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input int idx, input bit keep);
      exp_t e;
      int   waited;
      drive_vec(idx, e);
      waited = 0;
      #1;
      while (!in_ready && waited < 50) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (!in_ready) begin
         check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
      end else begin
         if (keep) begin
            exp_q.push_back(e);
            n_expect++;
         end
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_output", out_result, 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("result", out_result, mon_e.res);
            check_eq("flag_c", {60'd0, out_c}, {60'd0, mon_e.c});
            check_eq("flag_n", {60'd0, out_n}, {60'd0, mon_e.n});
            check_eq("flag_v", {60'd0, out_v}, {60'd0, mon_e.v});
            check_eq("flag_z", {60'd0, out_z}, {60'd0, mon_e.z});
            n_recv++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t tmp;
      int   sent;
      bit   need_new;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_op      = 2'd0;
      in_sat_en  = 1'b0;
      in_a       = '0;
      in_b       = '0;
      out_ready  = 1'b1;
      sticky_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out_result", out_result, 64'd0);
      check_eq("rst_flags", {48'd0, out_c, out_n, out_v, out_z}, 64'd0);
      check_eq("rst_sticky", {60'd0, sticky_v}, 64'd0);
      rst_n = 1'b1;
      #1;
      check_eq("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      for (int k = 0; k < 12; k++) begin
         send(k, 1'b1);
         in_valid = 1'b0;
         if (k == 0) begin
            check_eq("latency_after_s1", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
            check_eq("latency_after_s2", {63'd0, out_valid}, 64'd1);
         end
         repeat (4) @(posedge clk);
         #1;
         if (k == 0)
            check_eq("sticky0_clear", {63'd0, sticky_v[0]}, 64'd0);
         if (k == 1)
            check_eq("sticky0_set", {63'd0, sticky_v[0]}, 64'd1);
      end
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      check_eq("sticky_cleared", {60'd0, sticky_v}, 64'd0);

      // Back-to-back vectors with the consumer stalled for cycles 3..6
      sent = 0;
      need_new = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         if (sent < 6) begin
            if (need_new)
               drive_vec(sent, tmp);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= 3 && cyc <= 6) begin
            check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check_eq("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check_eq("bp_hold", out_result, exp_q[0].res);
         end
         need_new = 1'b0;
         if (in_valid && in_ready) begin
            exp_q.push_back(tmp);
            n_expect++;
            sent++;
            need_new = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check_eq("bp_sent", 64'(sent), 64'd6);

      // Reset with two vectors in flight
      out_ready = 1'b0;
      send(2, 1'b0);
      send(3, 1'b0);
      in_valid = 1'b0;
      check_eq("inflight_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("midrst_out_result", out_result, 64'd0);
      check_eq("midrst_flags", {48'd0, out_c, out_n, out_v, out_z}, 64'd0);
      check_eq("midrst_sticky", {60'd0, sticky_v}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check_eq("in_ready_after_midrst", {63'd0, in_ready}, 64'd1);
      repeat (5) @(posedge clk);
      #1;
      check_eq("no_emit_after_rst", {63'd0, out_valid}, 64'd0);

      // Clear coinciding with an overflowing handshake
      send(1, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("sticky_race_valid", {63'd0, out_valid}, 64'd1);
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      check_eq("sticky_set_wins", {63'd0, sticky_v[0]}, 64'd1);
      repeat (4) @(posedge clk);
      #1;

      check_eq("recv_count", 64'(n_recv), 64'(n_expect));
      check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("total_expected", 64'(n_expect), 64'd19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
